mastermind_game_ctrl: RTL and testbench

Game sequencer for the Mastermind arcade top. It converts coin pulses into credits and games, and gates game start on available credits. It collects the four-shape master pattern, then runs up to MAX_ROUNDS guess/grade rounds against the external grader datapath. It drives the game-count, leftover-credit, round and win/lose values consumed by the seven-segment and VGA display paths.

---
 rtl/mastermind_pkg.sv | 37 +++
 rtl/mastermind_game_ctrl_if.sv | 49 ++++
 rtl/mastermind_game_ctrl_credit_counter.sv | 68 ++++++
 rtl/mastermind_game_ctrl.sv | 134 +++++++++++++
 tb/tb_mastermind_game_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mastermind_pkg.sv
// -----------------------------------------------------------------------------
// mastermind_pkg
// Shared types and constants for the Mastermind game sequencer:
//   ctrl_state_t  - sequencer state encoding
//   shape_t       - 3-bit shape code, SHAPE_MAX is the largest legal code
//   COIN_*        - coin type encodings on coinValue
//   PATTERN_W     - width of a four-shape pattern
//   coin_credits  - credits carried by a coin type (0 for the invalid code)
// -----------------------------------------------------------------------------
package mastermind_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GRADE,
        ST_WIN,
        ST_LOSE
    } ctrl_state_t;

    typedef logic [2:0] shape_t;

    localparam shape_t SHAPE_MAX = 3'd5;

    localparam logic [1:0] COIN_NONE  = 2'b00;
    localparam logic [1:0] COIN_ONE   = 2'b01;
    localparam logic [1:0] COIN_TWO   = 2'b10;
    localparam logic [1:0] COIN_THREE = 2'b11;

    localparam int PATTERN_W = 12;

    // The coin encoding is its own credit value; the invalid code yields 0.
    function automatic logic [3:0] coin_credits(input logic [1:0] value);
        return {2'b00, value};
    endfunction

endpackage

// File: rtl/mastermind_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// mastermind_game_ctrl_if
// Bundles the game-board inputs, grader handshake and display outputs of the
// game sequencer.
//   master : the board/grader side (drives coins, buttons, grader results)
//   slave  : the sequencer (drives gradeReq, pattern and display values)
// -----------------------------------------------------------------------------
interface mastermind_game_ctrl_if;
    import mastermind_pkg::*;

    // board / grader -> sequencer
    logic                 coinInserted;
    logic [1:0]           coinValue;
    logic                 startGame;
    logic                 loadShapeNow;
    shape_t               loadShape;
    logic [1:0]           shapeLocation;
    logic                 gradeIt;
    logic [PATTERN_W-1:0] guess;
    logic                 gradeDone;
    logic [3:0]           znarly;
    logic [3:0]           zood;

    // sequencer -> grader / displays
    logic                 gradeReq;
    logic [PATTERN_W-1:0] gradeGuess;
    logic [PATTERN_W-1:0] masterPattern;
    logic [3:0]           numGames;
    logic [3:0]           leftOver;
    logic [3:0]           roundNumber;
    logic                 gameWon;
    logic                 gameOver;
    logic                 clearGame;

    modport master (
        output coinInserted, coinValue, startGame, loadShapeNow, loadShape,
               shapeLocation, gradeIt, guess, gradeDone, znarly, zood,
        input  gradeReq, gradeGuess, masterPattern, numGames, leftOver,
               roundNumber, gameWon, gameOver, clearGame
    );

    modport slave (
        input  coinInserted, coinValue, startGame, loadShapeNow, loadShape,
               shapeLocation, gradeIt, guess, gradeDone, znarly, zood,
        output gradeReq, gradeGuess, masterPattern, numGames, leftOver,
               roundNumber, gameWon, gameOver, clearGame
    );

endinterface

// File: rtl/mastermind_game_ctrl_credit_counter.sv
// -----------------------------------------------------------------------------
// credit_counter
// Converts coins into credits and stored games, saturating the game count.
//   clock, reset      : system clock, synchronous active-high reset
//   coin_inserted_i   : single-cycle coin pulse
//   coin_value_i      : coin type (00 invalid)
//   consume_i         : a game is being started this cycle
//   num_games_o       : stored games
//   left_over_o       : residual credits (0..CREDITS_PER_GAME-1)
//   game_avail_o      : at least one stored game
// -----------------------------------------------------------------------------
module credit_counter
    import mastermind_pkg::*;
#(
    parameter int MAX_GAMES        = 7,
    parameter int CREDITS_PER_GAME = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_inserted_i,
    input  logic [1:0] coin_value_i,
    input  logic       consume_i,
    output logic [3:0] num_games_o,
    output logic [3:0] left_over_o,
    output logic       game_avail_o
);

    logic [3:0] games_q, games_d;
    logic [3:0] left_q,  left_d;
    logic [4:0] sum;
    logic       coin_ok;

    always_comb begin
        games_d = games_q;
        left_d  = left_q;
        sum     = {1'b0, left_q} + {1'b0, coin_credits(coin_value_i)};
        // At saturation a coin is still taken when a start frees a slot in
        // the same cycle, so the net count never exceeds MAX_GAMES.
        coin_ok = coin_inserted_i && (coin_value_i != COIN_NONE) &&
                  ((games_q != 4'(MAX_GAMES)) || consume_i);
        if (coin_ok) begin
            if (sum >= 5'(CREDITS_PER_GAME)) begin
                games_d = games_q + 4'd1;
                left_d  = 4'(sum - 5'(CREDITS_PER_GAME));
            end else begin
                left_d  = sum[3:0];
            end
        end
        if (consume_i) begin
            games_d = games_d - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            games_q <= 4'd0;
            left_q  <= 4'd0;
        end else begin
            games_q <= games_d;
            left_q  <= left_d;
        end
    end

    assign num_games_o  = games_q;
    assign left_over_o  = left_q;
    assign game_avail_o = (games_q != 4'd0);

endmodule

// File: rtl/mastermind_game_ctrl.sv
// -----------------------------------------------------------------------------
// mastermind_game_ctrl
// Game sequencer: credit gating, master-pattern load and guess/grade rounds.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : coins, buttons, grader handshake and display values
// Build option: define FREE_PLAY_EN to start games without consuming credits.
// -----------------------------------------------------------------------------
module mastermind_game_ctrl
    import mastermind_pkg::*;
#(
    parameter int MAX_ROUNDS       = 8,
    parameter int MAX_GAMES        = 7,
    parameter int CREDITS_PER_GAME = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    mastermind_game_ctrl_if.slave   bus
);

    ctrl_state_t          state_q;
    logic [3:0]           mask_q;
    logic [PATTERN_W-1:0] pattern_q;
    logic [PATTERN_W-1:0] guess_q;
    logic                 req_q;
    logic [3:0]           round_q;
    logic                 won_q;
    logic                 over_q;
    logic                 clear_q;

    logic start_hit;
    logic start_ok;
    logic consume;
    logic game_avail;
    logic unused_zood;

    // The grader's partial-match count is display-only and not needed here.
    assign unused_zood = ^bus.zood;

    assign start_hit = bus.startGame &&
                       (state_q == ST_IDLE || state_q == ST_WIN || state_q == ST_LOSE);

`ifdef FREE_PLAY_EN
    assign start_ok = start_hit;
    assign consume  = 1'b0;
`else
    // The start decision uses the pre-coin game count.
    assign start_ok = start_hit && game_avail;
    assign consume  = start_ok;
`endif

    credit_counter #(
        .MAX_GAMES        (MAX_GAMES),
        .CREDITS_PER_GAME (CREDITS_PER_GAME)
    ) u_credit (
        .clock           (clock),
        .reset           (reset),
        .coin_inserted_i (bus.coinInserted),
        .coin_value_i    (bus.coinValue),
        .consume_i       (consume),
        .num_games_o     (bus.numGames),
        .left_over_o     (bus.leftOver),
        .game_avail_o    (game_avail)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mask_q    <= 4'd0;
            pattern_q <= '0;
            guess_q   <= '0;
            req_q     <= 1'b0;
            round_q   <= 4'd0;
            won_q     <= 1'b0;
            over_q    <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start_hit) begin
                        clear_q <= 1'b1;
                        won_q   <= 1'b0;
                        over_q  <= 1'b0;
                        round_q <= 4'd0;
                        mask_q  <= 4'd0;
                        state_q <= start_ok ? ST_LOAD : ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // The transition waits one cycle after the mask fills.
                    if (mask_q == 4'hF) begin
                        state_q <= ST_PLAY;
                        round_q <= 4'd1;
                    end else if (bus.loadShapeNow && (bus.loadShape <= SHAPE_MAX)) begin
                        pattern_q[3*bus.shapeLocation +: 3] <= bus.loadShape;
                        mask_q[bus.shapeLocation]           <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (bus.gradeIt) begin
                        guess_q <= bus.guess;
                        req_q   <= 1'b1;
                        state_q <= ST_GRADE;
                    end
                end
                ST_GRADE: begin
                    if (bus.gradeDone) begin
                        req_q <= 1'b0;
                        if (bus.znarly == 4'd4) begin
                            won_q   <= 1'b1;
                            state_q <= ST_WIN;
                        end else if (round_q == 4'(MAX_ROUNDS)) begin
                            over_q  <= 1'b1;
                            state_q <= ST_LOSE;
                        end else begin
                            round_q <= round_q + 4'd1;
                            state_q <= ST_PLAY;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.gradeReq      = req_q;
    assign bus.gradeGuess    = guess_q;
    assign bus.masterPattern = pattern_q;
    assign bus.roundNumber   = round_q;
    assign bus.gameWon       = won_q;
    assign bus.gameOver      = over_q;
    assign bus.clearGame     = clear_q;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mastermind_game_ctrl
// Directed scenarios plus randomized stimulus for mastermind_game_ctrl, every
// cycle compared against a behavioural game model kept in this bench.
// -----------------------------------------------------------------------------
module tb_mastermind_game_ctrl;

    localparam int MAXR = 8;
    localparam int MAXG = 7;
    localparam int CPG  = 4;
`ifdef FREE_PLAY_EN
    localparam bit FREE = 1'b1;
`else
    localparam bit FREE = 1'b0;
`endif

    // model phases
    localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_GRADE = 3, P_WIN = 4, P_LOSE = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mastermind_game_ctrl_if bus();

    mastermind_game_ctrl #(
        .MAX_ROUNDS       (MAXR),
        .MAX_GAMES        (MAXG),
        .CREDITS_PER_GAME (CPG)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model
    int   m_phase;
    int   m_games, m_left, m_round;
    int   m_pat[4];
    bit   m_loaded[4];
    bit   m_won, m_over, m_clear, m_req;
    int   m_gguess;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        int  cv, sum;
        bit  start_hit, take;
        if (rst) begin
            m_phase = P_IDLE; m_games = 0; m_left = 0; m_round = 0;
            m_won = 0; m_over = 0; m_clear = 0; m_req = 0; m_gguess = 0;
            for (int i = 0; i < 4; i++) begin m_pat[i] = 0; m_loaded[i] = 0; end
            return;
        end
        start_hit = bus.startGame &&
                    (m_phase == P_IDLE || m_phase == P_WIN || m_phase == P_LOSE);
        take = start_hit && (FREE || m_games > 0);
        // credits, using the game count from before this cycle
        cv = bus.coinInserted ? int'(bus.coinValue) : 0;
        if (cv != 0 && (m_games < MAXG || (take && !FREE))) begin
            sum = m_left + cv;
            if (sum >= CPG) begin m_games++; m_left = sum - CPG; end
            else m_left = sum;
        end
        if (take && !FREE) m_games--;
        m_clear = start_hit;
        case (m_phase)
            P_IDLE, P_WIN, P_LOSE: if (start_hit) begin
                m_won = 0; m_over = 0; m_round = 0;
                for (int i = 0; i < 4; i++) m_loaded[i] = 0;
                m_phase = take ? P_LOAD : P_IDLE;
            end
            P_LOAD: begin
                if (m_loaded[0] && m_loaded[1] && m_loaded[2] && m_loaded[3]) begin
                    m_phase = P_PLAY; m_round = 1;
                end else if (bus.loadShapeNow && bus.loadShape <= 5) begin
                    m_pat[bus.shapeLocation]    = int'(bus.loadShape);
                    m_loaded[bus.shapeLocation] = 1;
                end
            end
            P_PLAY: if (bus.gradeIt) begin
                m_gguess = int'(bus.guess); m_req = 1; m_phase = P_GRADE;
            end
            P_GRADE: if (bus.gradeDone) begin
                m_req = 0;
                if (bus.znarly == 4) begin m_won = 1; m_phase = P_WIN; end
                else if (m_round == MAXR) begin m_over = 1; m_phase = P_LOSE; end
                else begin m_round++; m_phase = P_PLAY; end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        int pat;
        pat = m_pat[0] + 8 * m_pat[1] + 64 * m_pat[2] + 512 * m_pat[3];
        check_eq("numGames",      int'(bus.numGames),      m_games);
        check_eq("leftOver",      int'(bus.leftOver),      m_left);
        check_eq("roundNumber",   int'(bus.roundNumber),   m_round);
        check_eq("gameWon",       int'(bus.gameWon),       int'(m_won));
        check_eq("gameOver",      int'(bus.gameOver),      int'(m_over));
        check_eq("clearGame",     int'(bus.clearGame),     int'(m_clear));
        check_eq("gradeReq",      int'(bus.gradeReq),      int'(m_req));
        check_eq("gradeGuess",    int'(bus.gradeGuess),    m_gguess);
        check_eq("masterPattern", int'(bus.masterPattern), pat);
    endtask

    task automatic clear_pulses();
        bus.coinInserted = 0; bus.startGame = 0; bus.loadShapeNow = 0;
        bus.gradeIt = 0; bus.gradeDone = 0;
    endtask

    // one clock: predict, advance, compare, drop pulses
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
        clear_pulses();
    endtask

    task automatic coin(input int v);
        bus.coinInserted = 1; bus.coinValue = 2'(v); step();
    endtask

    task automatic start();
        bus.startGame = 1; step();
    endtask

    task automatic load(input int loc, input int shp);
        bus.loadShapeNow = 1; bus.shapeLocation = 2'(loc); bus.loadShape = 3'(shp); step();
    endtask

    task automatic load_all();
        load(0, 7); load(0, 1); load(1, 2); load(2, 3); load(3, 4); step();
    endtask

    task automatic grade_round(input int z);
        bus.gradeIt = 1; bus.guess = 12'($urandom); step();
        repeat ($urandom_range(0, 3)) step();
        bus.gradeDone = 1; bus.znarly = 4'(z); bus.zood = 4'($urandom_range(0, 4)); step();
    endtask

    task automatic buy_one_game();
        coin(3); coin(1);
    endtask

    initial begin
        int prev_left, guard;
        clear_pulses();
        bus.coinValue = 0; bus.loadShape = 0; bus.shapeLocation = 0;
        bus.guess = 0; bus.znarly = 0; bus.zood = 0;

        // reset state
        rst = 1; step(); step();
        check_eq("rst_numGames", int'(bus.numGames), 0);
        rst = 0;

        // coin arithmetic
        coin(3); coin(2);
        check_eq("coin_games1", int'(bus.numGames), 1);
        check_eq("coin_left1",  int'(bus.leftOver), 1);
        coin(3);
        check_eq("coin_games2", int'(bus.numGames), 2);
        check_eq("coin_left0",  int'(bus.leftOver), 0);
        coin(0);
        check_eq("coin_invalid", int'(bus.leftOver), 0);

        // saturation
        guard = 0;
        while (m_games < MAXG && guard < 20) begin coin(3); guard++; end
        check_eq("sat_reach", int'(bus.numGames), MAXG);
        prev_left = int'(bus.leftOver);
        coin(3);
        check_eq("sat_games", int'(bus.numGames), MAXG);
        check_eq("sat_left",  int'(bus.leftOver), prev_left);
        // coin together with a start at saturation is accepted
        bus.coinInserted = 1; bus.coinValue = 2'd3; start();

        // start with no games
        rst = 1; step(); rst = 0;
        start();
        check_eq("start0_clear", int'(bus.clearGame), 1);
        step();
        check_eq("start0_clear_width", int'(bus.clearGame), 0);
        buy_one_game();
        check_eq("buy_games", int'(bus.numGames), 1);
        start();
        check_eq("start1_games", int'(bus.numGames), FREE ? 1 : 0);

        // pattern load
        load(0, 7); load(0, 1); load(1, 2); load(2, 3); load(3, 4);
        check_eq("pattern", int'(bus.masterPattern), 12'o4321);
        check_eq("round_preplay", int'(bus.roundNumber), 0);
        step();
        check_eq("round_first", int'(bus.roundNumber), 1);

        // losing game
        for (int r = 0; r < MAXR; r++) grade_round(1);
        check_eq("lose_over",  int'(bus.gameOver), 1);
        check_eq("lose_round", int'(bus.roundNumber), MAXR);
        bus.gradeIt = 1; step(); step();
        check_eq("lose_noreq", int'(bus.gradeReq), 0);

        // winning game in round 3
        buy_one_game(); start(); load_all();
        grade_round(1); grade_round(1); grade_round(4);
        check_eq("win_flag",  int'(bus.gameWon), 1);
        check_eq("win_round", int'(bus.roundNumber), 3);
        step();

        // reset while grading
        buy_one_game(); start(); load_all();
        bus.gradeIt = 1; bus.guess = 12'o5050; step();
        check_eq("req_high", int'(bus.gradeReq), 1);
        rst = 1; step(); rst = 0;
        check_eq("rst_req",   int'(bus.gradeReq), 0);
        check_eq("rst_games", int'(bus.numGames), 0);

`ifdef FREE_PLAY_EN
        start(); load_all();
        check_eq("free_round", int'(bus.roundNumber), 1);
`endif

        // randomized play
        for (int c = 0; c < 4000; c++) begin
            rst               = ($urandom_range(0, 599) == 0);
            bus.coinInserted  = ($urandom_range(0, 7) == 0);
            bus.coinValue     = 2'($urandom_range(0, 3));
            bus.startGame     = ($urandom_range(0, 15) == 0);
            bus.loadShapeNow  = ($urandom_range(0, 2) == 0);
            bus.loadShape     = 3'($urandom_range(0, 7));
            bus.shapeLocation = 2'($urandom_range(0, 3));
            bus.gradeIt       = ($urandom_range(0, 3) == 0);
            bus.guess         = 12'($urandom);
            bus.gradeDone     = ($urandom_range(0, 3) == 0);
            bus.znarly        = ($urandom_range(0, 5) == 0) ? 4'd4 : 4'($urandom_range(0, 3));
            bus.zood          = 4'($urandom_range(0, 4));
            step();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
